// File: rtl/softmax_req_scheduler.sv
// softmax_req_scheduler: round-robin scheduler sharing one fp16_softmax datapath among NUM_REQ requesters.
// Optional macro SOFTMAX_SCHED_ARGMAX_EN adds rsp_argmax, the index of the largest result lane.
module softmax_req_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int IN_OUT_NUM  = 10,
  parameter int TIMEOUT_CYC = 64,
  parameter int ID_W        = 2
) (
  input  logic                             clk,
  input  logic                             reset_b,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*IN_OUT_NUM*16-1:0] req_data,
  output logic [NUM_REQ-1:0]               grant,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [ID_W-1:0]                  rsp_id,
  output logic [IN_OUT_NUM*16-1:0]         rsp_data,
`ifdef SOFTMAX_SCHED_ARGMAX_EN
  output logic [$clog2(IN_OUT_NUM)-1:0]    rsp_argmax,
`endif
  output logic                             timeout_err,
  output logic                             sm_start_op,
  output logic                             sm_clear,
  output logic [IN_OUT_NUM*16-1:0]         sm_input_neuron_val,
  input  logic [IN_OUT_NUM*16-1:0]         sm_output_neuron_val,
  input  logic                             sm_valid
);
  localparam int W     = IN_OUT_NUM * 16;
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  typedef enum logic [2:0] {INIT, IDLE, LOAD, START, WAIT, RESP, CLEAR} state_t;
  state_t state, state_nx;
  logic [ID_W-1:0] ptr, sel, idx;
  logic [CNT_W-1:0] cnt;
  logic found, timeout, run;
  assign run     = !reset_b;
  assign timeout = cnt == CNT_W'(TIMEOUT_CYC - 1);
  // scan downward from ptr+NUM_REQ-1 so the last hit is the first set bit at or after ptr
  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      INIT:    state_nx = IDLE;
      IDLE:    state_nx = found ? LOAD : IDLE;
      LOAD:    state_nx = START;
      START:   state_nx = WAIT;
      WAIT:    state_nx = sm_valid ? RESP : timeout ? CLEAR : WAIT;
      RESP:    state_nx = rsp_ready ? CLEAR : RESP;
      CLEAR:   state_nx = IDLE;
      default: state_nx = INIT;
    endcase
    grant       = (run && state == IDLE && found) ? NUM_REQ'(1) << sel : '0;
    sm_clear    = run && (state == INIT || state == CLEAR);
    sm_start_op = run && state == START;
    rsp_valid   = run && state == RESP;
    timeout_err = run && state == WAIT && !sm_valid && timeout;
  end
  always_ff @(posedge clk) begin
    if (reset_b) begin
      state               <= INIT;
      ptr                 <= '0;
      cnt                 <= '0;
      sm_input_neuron_val <= '0;
      rsp_data            <= '0;
      rsp_id              <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state == START) ? '0 : (state == WAIT) ? cnt + 1'b1 : cnt;
      if (state == IDLE && found) begin
        sm_input_neuron_val <= req_data[int'(sel)*W +: W];
        rsp_id              <= sel;
        ptr                 <= (sel == ID_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
      end
      if (state == WAIT && sm_valid) rsp_data <= sm_output_neuron_val;
    end
  end
`ifdef SOFTMAX_SCHED_ARGMAX_EN
  localparam int AM_W = $clog2(IN_OUT_NUM);
  logic [AM_W-1:0] am;
  logic [14:0] am_v;
  // strict greater-than keeps the lowest index on ties; sign bit ignored
  always_comb begin
    am   = '0;
    am_v = sm_output_neuron_val[14:0];
    for (int i = 1; i < IN_OUT_NUM; i++)
      if (sm_output_neuron_val[i*16 +: 15] > am_v) begin
        am   = AM_W'(i);
        am_v = sm_output_neuron_val[i*16 +: 15];
      end
  end
  always_ff @(posedge clk) begin
    if (reset_b) rsp_argmax <= '0;
    else if (state == WAIT && sm_valid) rsp_argmax <= am;
  end
`endif
endmodule

// File: tb/tb_softmax_req_scheduler.sv
// tb_softmax_req_scheduler: directed bench with a timeline model of the scheduler and a softmax datapath stub.
module tb_softmax_req_scheduler;
  localparam int N = 4, L = 10, TO = 64, IDW = 2, W = L * 16, AMW = $clog2(L);
  logic clk = 0, reset_b = 1, rsp_ready = 1, sm_valid = 0;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [W-1:0] sm_out = '0;
  logic [N-1:0] grant;
  logic rsp_valid, timeout_err, sm_start_op, sm_clear;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0] rsp_data, sm_in;
`ifdef SOFTMAX_SCHED_ARGMAX_EN
  logic [AMW-1:0] rsp_argmax;
  int am_seen;
`endif
  int checks = 0, failures = 0;
  always #5 clk = ~clk;

  softmax_req_scheduler #(.NUM_REQ(N), .IN_OUT_NUM(L), .TIMEOUT_CYC(TO), .ID_W(IDW)) dut (
    .clk(clk), .reset_b(reset_b), .req(req), .req_data(req_data), .grant(grant),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
`ifdef SOFTMAX_SCHED_ARGMAX_EN
    .rsp_argmax(rsp_argmax),
`endif
    .timeout_err(timeout_err), .sm_start_op(sm_start_op), .sm_clear(sm_clear),
    .sm_input_neuron_val(sm_in), .sm_output_neuron_val(sm_out), .sm_valid(sm_valid));

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s @%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask
  task automatic chk_i(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s @%0t got=%0d exp=%0d", name, $time, got, exp);
    end
  endtask

  function automatic logic [W-1:0] fill(input logic [15:0] v);
    return {L{v}};
  endfunction
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  function automatic int argmax_of(input logic [W-1:0] v);
    int best = 0;
    for (int i = 1; i < L; i++) if (v[i*16 +: 15] > v[best*16 +: 15]) best = i;
    return best;
  endfunction
  function automatic int oh2i(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  // timeline model: everything is expressed as cycle numbers relative to the last grant / handshake
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  bit m_init = 1, busy = 0, waiting = 0, resp_pend = 0;
  int avail_at = 0, start_at = -1000, clear_at = -1000, resp_from = 0, m_ptr = 0, m_am = 0, pk;
  logic [IDW-1:0] m_id = '0;
  logic [W-1:0] m_vec = '0, m_data = '0;
  logic [N-1:0] e_grant;
  logic e_clear, e_start, e_valid, e_to;
  int g_cyc[$], g_id[$], s_cyc[$], c_cyc[$], t_cyc[$], r_id[$];
  int hs_cyc = -1;

  initial forever begin
    @(negedge clk);
    pk = rr_pick(req, m_ptr);
    e_grant = '0;
    if (!reset_b && !m_init && !busy && cyc >= avail_at && pk >= 0) e_grant[pk] = 1'b1;
    e_clear = !reset_b && (m_init || cyc == clear_at);
    e_start = !reset_b && cyc == start_at;
    e_valid = !reset_b && resp_pend && cyc >= resp_from;
    e_to    = !reset_b && waiting && cyc == start_at + TO && !sm_valid;
    chk("grant", W'(grant), W'(e_grant));
    chk("sm_clear", W'(sm_clear), W'(e_clear));
    chk("sm_start_op", W'(sm_start_op), W'(e_start));
    chk("rsp_valid", W'(rsp_valid), W'(e_valid));
    chk("timeout_err", W'(timeout_err), W'(e_to));
    chk("rsp_id", W'(rsp_id), W'(m_id));
    chk("rsp_data", rsp_data, m_data);
    chk("sm_input_neuron_val", sm_in, m_vec);
`ifdef SOFTMAX_SCHED_ARGMAX_EN
    if (e_valid) chk("rsp_argmax", W'(rsp_argmax), W'(m_am));
`endif
    if (grant != '0) begin g_cyc.push_back(cyc); g_id.push_back(oh2i(grant)); end
    if (sm_start_op) s_cyc.push_back(cyc);
    if (sm_clear) c_cyc.push_back(cyc);
    if (timeout_err) t_cyc.push_back(cyc);
    if (rsp_valid && rsp_ready) begin hs_cyc = cyc; r_id.push_back(int'(rsp_id)); end
    if (reset_b) begin
      m_init = 1; busy = 0; waiting = 0; resp_pend = 0; start_at = -1000; clear_at = -1000;
      m_ptr = 0; m_id = '0; m_vec = '0; m_data = '0; m_am = 0;
    end else begin
      if (m_init) begin m_init = 0; avail_at = cyc + 1; end
      if (e_grant != '0) begin
        busy = 1; waiting = 1; m_id = IDW'(pk); m_vec = req_data[pk*W +: W];
        m_ptr = (pk + 1) % N; start_at = cyc + 2;
      end
      if (waiting && cyc > start_at && cyc <= start_at + TO) begin
        if (sm_valid) begin
          waiting = 0; resp_pend = 1; resp_from = cyc + 1; m_data = sm_out; m_am = argmax_of(sm_out);
        end else if (cyc == start_at + TO) begin
          waiting = 0; busy = 0; clear_at = cyc + 1; avail_at = cyc + 2;
        end
      end
      if (e_valid && rsp_ready) begin resp_pend = 0; busy = 0; clear_at = cyc + 1; avail_at = cyc + 2; end
    end
  end

  // datapath stub: answers stub_delay cycles into WAIT, never when stub_delay < 0
  int stub_delay = 0;
  logic [W-1:0] stub_out = '0;
  initial forever begin
    @(negedge clk);
    if (sm_start_op && stub_delay >= 0) begin
      repeat (stub_delay + 1) @(posedge clk);
      #1 sm_valid = 1; sm_out = stub_out;
      @(posedge clk); #1 sm_valid = 0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1);
  end

  int rid_seen;
  logic [W-1:0] rdata_seen, v;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_grant(input int budget);
    int i = 0;
    @(negedge clk);
    while (grant == '0 && i < budget) begin @(negedge clk); i++; end
    chk_i("grant_within_budget", int'(grant != '0), 1);
    @(posedge clk); #1;
  endtask
  task automatic wait_rsp(input int budget);
    int i = 0;
    @(negedge clk);
    while (!rsp_valid && i < budget) begin @(negedge clk); i++; end
    chk_i("rsp_within_budget", int'(rsp_valid), 1);
    rid_seen = int'(rsp_id); rdata_seen = rsp_data;
`ifdef SOFTMAX_SCHED_ARGMAX_EN
    am_seen = int'(rsp_argmax);
`endif
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    reset_b = 1;
    tick(2);
    @(negedge clk);
    chk("reset_outputs_zero", {grant, sm_clear, sm_start_op, rsp_valid, timeout_err, rsp_id},
        '0);
    chk("reset_regs_zero", sm_in | rsp_data, '0);
    @(posedge clk); #1 reset_b = 0;
  endtask

  initial begin
    int gb, rb, cb, tb0;
    // single request, real-like result 0.1 on every lane
    do_reset();
    for (int r = 0; r < N; r++) req_data[r*W +: W] = fill(16'h3C00 + 16'(r));
    stub_delay = 3; stub_out = fill(16'h2E66);
    req = 4'b0001;
    wait_grant(20);
    req = '0;
    chk_i("t1_grant_id", g_id[$], 0);
    wait_rsp(100);
    tick(3);
    chk_i("t1_start_latency", s_cyc[$] - g_cyc[$], 2);
    chk_i("t1_rsp_id", rid_seen, 0);
    chk("t1_rsp_data", rdata_seen, fill(16'h2E66));
    chk_i("t1_clear_after_handshake", c_cyc[$] - hs_cyc, 1);
    // all four requesting: strict round robin from a reset pointer
    do_reset();
    stub_delay = 1;
    gb = g_id.size(); rb = r_id.size();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) wait_grant(50);
    req = '0;
    tick(20);
    begin
      int exp_ids[5] = '{0, 1, 2, 3, 0};
      for (int k = 0; k < 5; k++) begin
        chk_i("t2_grant_order", g_id[gb + k], exp_ids[k]);
        chk_i("t2_rsp_id_order", r_id[rb + k], exp_ids[k]);
      end
    end
    // consumer stall: response held, no grant or clear until ready
    rsp_ready = 0;
    for (int i = 0; i < L; i++) stub_out[i*16 +: 16] = 16'h1000 + 16'(i);
    req = 4'b0100;
    wait_grant(20);
    req = 4'b0001;
    wait_rsp(100);
    gb = g_cyc.size(); cb = c_cyc.size();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("t3_hold_valid", W'(rsp_valid), W'(1'b1));
      chk("t3_hold_id", W'(rsp_id), W'(2'd2));
      chk("t3_hold_data", rsp_data, rdata_seen);
    end
    chk_i("t3_no_grant_while_stalled", g_cyc.size() - gb, 0);
    chk_i("t3_no_clear_while_stalled", c_cyc.size() - cb, 0);
    @(posedge clk); #1 rsp_ready = 1;
    wait_grant(10);
    req = '0;
    chk_i("t3_clear_after_ready", c_cyc[$] - hs_cyc, 1);
    chk_i("t3_next_grant_latency", g_cyc[$] - hs_cyc, 2);
    chk_i("t3_next_grant_id", g_id[$], 0);
    tick(15);
    // datapath never answers: abandon after the wait budget, then serve the pending requester
    stub_delay = -1;
    rb = r_id.size(); tb0 = t_cyc.size();
    req = 4'b0001;
    wait_grant(20);
    req = 4'b0100;
    wait_grant(100);
    stub_delay = 2;
    req = '0;
    chk_i("t4_one_timeout", t_cyc.size() - tb0, 1);
    chk_i("t4_timeout_after_start", t_cyc[$] - s_cyc[$], 64);
    chk_i("t4_clear_after_timeout", c_cyc[$] - t_cyc[$], 1);
    chk_i("t4_grant_after_timeout", g_cyc[$] - t_cyc[$], 2);
    chk_i("t4_pending_granted", g_id[$], 2);
    chk_i("t4_no_response", r_id.size() - rb, 0);
    tick(15);
    // reset in the middle of WAIT
    stub_delay = -1;
    req = 4'b0001;
    wait_grant(20);
    req = '0;
    tick(6);
    reset_b = 1;
    tick(1);
    @(negedge clk);
    chk("t5_outputs_zero", {grant, sm_clear, sm_start_op, rsp_valid, timeout_err, rsp_id}, '0);
    chk("t5_regs_zero", sm_in | rsp_data, '0);
    @(posedge clk); #1 reset_b = 0;
    cb = c_cyc.size();
    stub_delay = 0;
    req = 4'b1010;
    wait_grant(10);
    req = '0;
    chk_i("t5_single_init_clear", c_cyc.size() - cb, 1);
    chk_i("t5_grant_after_reset", g_id[$], 1);
    tick(15);
    // argmax vectors: single peak, tie, all zero
    stub_delay = 2;
    for (int t = 0; t < 3; t++) begin
      v = (t == 2) ? '0 : fill(16'h2000);
      if (t == 0) v[7*16 +: 16] = 16'h3B00;
      if (t == 1) begin v[2*16 +: 16] = 16'h3800; v[5*16 +: 16] = 16'h3800; end
      stub_out = v;
      req = 4'b0001;
      wait_grant(20);
      req = '0;
      wait_rsp(50);
      chk("t6_rsp_data", rdata_seen, v);
`ifdef SOFTMAX_SCHED_ARGMAX_EN
      chk_i("t6_argmax", am_seen, (t == 0) ? 7 : (t == 1) ? 2 : 0);
`endif
      tick(5);
    end
    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
